// File: rtl/lbp_pkg.sv
// Shared definitions for the LBP window fetch block: image geometry,
// FSM state encoding, scan directions and the 3x3 window slot / code bit map.
package lbp_pkg;

  localparam int IMG_W   = 128;
  localparam int COORD_W = $clog2(IMG_W);

  // Centre address of the last pixel of the snake scan, {row, col}
  localparam logic [2*COORD_W-1:0] LAST_ADDR = {7'd126, 7'd1};

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    FETCH,
    CAP,
    OUT,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    DIR_RIGHT,
    DIR_LEFT,
    DIR_DOWN
  } dir_e;

  // Window slots in raster order, slot = 3*row + col inside the 3x3 window
  localparam int SLOT_TL = 0;
  localparam int SLOT_T  = 1;
  localparam int SLOT_TR = 2;
  localparam int SLOT_L  = 3;
  localparam int SLOT_C  = 4;
  localparam int SLOT_R  = 5;
  localparam int SLOT_BL = 6;
  localparam int SLOT_B  = 7;
  localparam int SLOT_BR = 8;

  // Bit position of each neighbour inside the LBP code
  localparam int BIT_TL = 0;
  localparam int BIT_T  = 1;
  localparam int BIT_TR = 2;
  localparam int BIT_L  = 3;
  localparam int BIT_R  = 4;
  localparam int BIT_BL = 5;
  localparam int BIT_B  = 6;
  localparam int BIT_BR = 7;

endpackage

// File: rtl/lbp_encode.sv
// Combinational LBP encoder: each neighbour sets its code bit when it is
// greater than or equal to the window centre (unsigned compare).
module lbp_encode
  import lbp_pkg::*;
(
  input  logic [8:0][7:0] window_i,
  output logic [7:0]      code_o
);

  logic [7:0] centre;

  assign centre = window_i[SLOT_C];

  assign code_o[BIT_TL] = (window_i[SLOT_TL] >= centre);
  assign code_o[BIT_T]  = (window_i[SLOT_T]  >= centre);
  assign code_o[BIT_TR] = (window_i[SLOT_TR] >= centre);
  assign code_o[BIT_L]  = (window_i[SLOT_L]  >= centre);
  assign code_o[BIT_R]  = (window_i[SLOT_R]  >= centre);
  assign code_o[BIT_BL] = (window_i[SLOT_BL] >= centre);
  assign code_o[BIT_B]  = (window_i[SLOT_B]  >= centre);
  assign code_o[BIT_BR] = (window_i[SLOT_BR] >= centre);

endmodule

// File: rtl/lbp_window_fetch.sv
// LBP window fetch: keeps the 3x3 gray window around the controller's centre
// address, fetches only the strip exposed by each snake-scan move, writes the
// LBP code and pulses the controller to advance.
// Optional feature: define LBP_PERF_CNT_EN to add the fetch_cnt request counter.
module lbp_window_fetch
  import lbp_pkg::*;
#(
  parameter  int IMG_W = 128,
  localparam int CW    = $clog2(IMG_W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [2*CW-1:0] gray_addr,
  input  logic [7:0]    gray_data,
  input  logic [2*CW-1:0] lbp_addr,
  input  logic          fill_right,
  input  logic          fill_left,
  input  logic          fill_down,
  output logic          lbp_addr_en,
  output logic          lbp_valid,
  output logic [7:0]    lbp_data,
  output logic          finish
`ifdef LBP_PERF_CNT_EN
  ,
  output logic [15:0]   fetch_cnt
`endif
);

  state_e          state_q;
  logic [3:0]      reqCnt_q;
  logic            pendValid_q;
  logic [3:0]      pendSlot_q;
  logic [8:0][7:0] window_q;
  logic [8:0][7:0] window_d;
  logic            lbpValid_q;
  logic [7:0]      lbpData_q;
  logic            finish_q;

  dir_e            dir;
  logic [1:0]      rOff;
  logic [1:0]      cOff;
  logic [CW-1:0]   centreRow;
  logic [CW-1:0]   centreCol;
  logic [CW-1:0]   reqRow;
  logic [CW-1:0]   reqCol;
  logic [3:0]      reqSlot;
  logic [7:0]      code;

  assign centreRow = lbp_addr[2*CW-1:CW];
  assign centreCol = lbp_addr[CW-1:0];

  // Direction of the last move, right beats left beats down; no flag at all
  // only happens outside the protocol and is treated as a down move.
  always_comb begin
    dir = DIR_DOWN;
    if (fill_right)     dir = DIR_RIGHT;
    else if (fill_left) dir = DIR_LEFT;
    else if (fill_down) dir = DIR_DOWN;
  end

  // Window-relative offset (0..2 meaning -1..+1) of the pixel requested this cycle
  always_comb begin
    gray_req = 1'b0;
    rOff     = 2'd0;
    cOff     = 2'd0;
    case (state_q)
      INIT: begin
        gray_req = 1'b1;
        case (reqCnt_q)
          4'd0:    begin rOff = 2'd0; cOff = 2'd0; end
          4'd1:    begin rOff = 2'd0; cOff = 2'd1; end
          4'd2:    begin rOff = 2'd0; cOff = 2'd2; end
          4'd3:    begin rOff = 2'd1; cOff = 2'd0; end
          4'd4:    begin rOff = 2'd1; cOff = 2'd1; end
          4'd5:    begin rOff = 2'd1; cOff = 2'd2; end
          4'd6:    begin rOff = 2'd2; cOff = 2'd0; end
          4'd7:    begin rOff = 2'd2; cOff = 2'd1; end
          default: begin rOff = 2'd2; cOff = 2'd2; end
        endcase
      end
      FETCH: begin
        gray_req = 1'b1;
        case (dir)
          DIR_RIGHT: begin rOff = reqCnt_q[1:0]; cOff = 2'd2; end
          DIR_LEFT:  begin rOff = reqCnt_q[1:0]; cOff = 2'd0; end
          default:   begin rOff = 2'd2;          cOff = reqCnt_q[1:0]; end
        endcase
      end
      default: ;
    endcase
  end

  assign reqRow    = centreRow + CW'(rOff) - CW'(1);
  assign reqCol    = centreCol + CW'(cOff) - CW'(1);
  assign reqSlot   = {1'b0, rOff, 1'b0} + {2'b00, rOff} + {2'b00, cOff};
  assign gray_addr = gray_req ? {reqRow, reqCol} : '0;

  // Next window: shift on the first FETCH cycle when the move direction is
  // stable, then drop in whatever datum the ROM is returning this cycle.
  always_comb begin
    window_d = window_q;
    if (state_q == FETCH && reqCnt_q == 4'd0) begin
      case (dir)
        DIR_RIGHT: begin
          window_d[0] = window_q[1]; window_d[1] = window_q[2];
          window_d[3] = window_q[4]; window_d[4] = window_q[5];
          window_d[6] = window_q[7]; window_d[7] = window_q[8];
        end
        DIR_LEFT: begin
          window_d[2] = window_q[1]; window_d[1] = window_q[0];
          window_d[5] = window_q[4]; window_d[4] = window_q[3];
          window_d[8] = window_q[7]; window_d[7] = window_q[6];
        end
        default: begin
          window_d[0] = window_q[3]; window_d[1] = window_q[4];
          window_d[2] = window_q[5]; window_d[3] = window_q[6];
          window_d[4] = window_q[7]; window_d[5] = window_q[8];
        end
      endcase
    end
    if (pendValid_q) window_d[pendSlot_q] = gray_data;
  end

  lbp_encode uEncode (
    .window_i (window_d),
    .code_o   (code)
  );

  // Main FSM with the window, pending-datum slot tracker and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      reqCnt_q    <= 4'd0;
      pendValid_q <= 1'b0;
      pendSlot_q  <= 4'd0;
      window_q    <= '0;
      lbpValid_q  <= 1'b0;
      lbpData_q   <= 8'd0;
      finish_q    <= 1'b0;
    end else begin
      pendValid_q <= gray_req;
      pendSlot_q  <= reqSlot;
      window_q    <= window_d;
      lbpValid_q  <= (state_q == CAP);
      if (state_q == CAP) lbpData_q <= code;
      case (state_q)
        IDLE: begin
          if (gray_ready) begin
            state_q  <= INIT;
            reqCnt_q <= 4'd0;
          end
        end
        INIT: begin
          if (reqCnt_q == 4'd8) begin
            state_q  <= CAP;
            reqCnt_q <= 4'd0;
          end else begin
            reqCnt_q <= reqCnt_q + 4'd1;
          end
        end
        FETCH: begin
          if (reqCnt_q == 4'd2) begin
            state_q  <= CAP;
            reqCnt_q <= 4'd0;
          end else begin
            reqCnt_q <= reqCnt_q + 4'd1;
          end
        end
        CAP: state_q <= OUT;
        OUT: begin
          if (lbp_addr == LAST_ADDR) begin
            state_q  <= DONE;
            finish_q <= 1'b1;
          end else begin
            state_q  <= FETCH;
          end
        end
        DONE: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lbp_valid   = lbpValid_q;
  assign lbp_addr_en = lbpValid_q;
  assign lbp_data    = lbpData_q;
  assign finish      = finish_q;

`ifdef LBP_PERF_CNT_EN
  logic [15:0] fetchCnt_q;

  // Saturating count of ROM request cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetchCnt_q <= 16'd0;
    end else if (gray_req && fetchCnt_q != 16'hFFFF) begin
      fetchCnt_q <= fetchCnt_q + 16'd1;
    end
  end

  assign fetch_cnt = fetchCnt_q;
`endif

endmodule

// File: tb/tb_lbp_window_fetch.sv
// Bench for lbp_window_fetch: a gray ROM model, a snake-scan address
// controller model and a reference LBP computed straight from the image.
module tb_lbp_window_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        gray_ready = 1'b0;
  logic        gray_req;
  logic [13:0] gray_addr;
  logic [7:0]  gray_data = 8'd0;
  logic [13:0] lbp_addr;
  logic        fill_right, fill_left, fill_down;
  logic        lbp_addr_en, lbp_valid;
  logic [7:0]  lbp_data;
  logic        finish;
`ifdef LBP_PERF_CNT_EN
  logic [15:0] fetch_cnt;
`endif

  int compCnt = 0;
  int errCnt  = 0;

  logic [7:0]  img [0:16383];
  logic [13:0] startAddr = 14'd0;
  logic [6:0]  ctrlRow, ctrlCol;
  logic        romPend = 1'b0;
  logic [13:0] romAddr = 14'd0;
  logic [13:0] reqLog [$];
  logic [13:0] expQ [$];

  lbp_window_fetch #(.IMG_W(128)) dut (
    .clk         (clk),
    .reset       (reset),
    .gray_ready  (gray_ready),
    .gray_req    (gray_req),
    .gray_addr   (gray_addr),
    .gray_data   (gray_data),
    .lbp_addr    (lbp_addr),
    .fill_right  (fill_right),
    .fill_left   (fill_left),
    .fill_down   (fill_down),
    .lbp_addr_en (lbp_addr_en),
    .lbp_valid   (lbp_valid),
    .lbp_data    (lbp_data),
    .finish      (finish)
`ifdef LBP_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign lbp_addr = {ctrlRow, ctrlCol};

  // Controller model: snake scan, odd rows run right, even rows run left
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrlRow    <= startAddr[13:7];
      ctrlCol    <= startAddr[6:0];
      fill_right <= 1'b0;
      fill_left  <= 1'b0;
      fill_down  <= 1'b0;
    end else if (lbp_addr_en) begin
      fill_right <= 1'b0;
      fill_left  <= 1'b0;
      fill_down  <= 1'b0;
      if (ctrlRow[0] && ctrlCol < 7'd126) begin
        ctrlCol <= ctrlCol + 7'd1;  fill_right <= 1'b1;
      end else if (!ctrlRow[0] && ctrlCol > 7'd1) begin
        ctrlCol <= ctrlCol - 7'd1;  fill_left <= 1'b1;
      end else begin
        ctrlRow <= ctrlRow + 7'd1;  fill_down <= 1'b1;
      end
    end
  end

  // Request sampling away from the clock edge, plus the request log
  always @(negedge clk) begin
    romPend <= gray_req;
    romAddr <= gray_addr;
    if (gray_req) reqLog.push_back(gray_addr);
  end

  // ROM model: data one cycle after the request, garbage otherwise
  always @(posedge clk) begin
    gray_data <= romPend ? img[romAddr] : 8'($urandom);
  end

  function automatic logic [13:0] addrOf(int r, int c);
    return 14'(r * 128 + c);
  endfunction

  function automatic logic [7:0] lbpRef(int r, int c);
    int dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    logic [7:0] g;
    logic [7:0] res;
    g   = img[addrOf(r, c)];
    res = 8'd0;
    for (int k = 0; k < 8; k++) res[k] = (img[addrOf(r + dr[k], c + dc[k])] >= g);
    return res;
  endfunction

  // Pixels a centre needs that the previous window did not hold
  function automatic void buildExp(bit first, int pr, int pc, int r, int c);
    expQ.delete();
    if (first) begin
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++) expQ.push_back(addrOf(r + dr, c + dc));
    end else if (c == pc + 1) begin
      for (int d = -1; d <= 1; d++) expQ.push_back(addrOf(r + d, c + 1));
    end else if (c == pc - 1) begin
      for (int d = -1; d <= 1; d++) expQ.push_back(addrOf(r + d, c - 1));
    end else begin
      for (int d = -1; d <= 1; d++) expQ.push_back(addrOf(r + 1, c + d));
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compCnt++;
    assert (obs === exp) else begin
      errCnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_gray_req"}, gray_req, 0);
    checkOutput({tag, "_gray_addr"}, gray_addr, 0);
    checkOutput({tag, "_lbp_valid"}, lbp_valid, 0);
    checkOutput({tag, "_lbp_addr_en"}, lbp_addr_en, 0);
    checkOutput({tag, "_lbp_data"}, lbp_data, 0);
    checkOutput({tag, "_finish"}, finish, 0);
  endtask

  // Reset, place the controller at a start centre and raise gray_ready
  task automatic applyStimulus(input int r, input int c);
    gray_ready = 1'b0;
    startAddr  = addrOf(r, c);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    reqLog.delete();
    @(negedge clk);
    gray_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("first_req", gray_req, 1);
    checkOutput("first_addr", gray_addr, addrOf(r - 1, c - 1));
  endtask

  task automatic waitValid(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!lbp_valid && cyc < 40);
  endtask

  // Wait for one result and check timing, code and the fetches that led to it
  task automatic checkPixel(input string tag, input int expCyc, input bit first,
                            input int pr, input int pc, output int r, output int c);
    int cyc;
    int n;
    waitValid(cyc);
    r = int'(ctrlRow);
    c = int'(ctrlCol);
    checkOutput({tag, "_valid"}, lbp_valid, 1);
    checkOutput({tag, "_latency"}, cyc, expCyc);
    checkOutput({tag, "_addr_en"}, lbp_addr_en, 1);
    checkOutput({tag, "_data"}, lbp_data, lbpRef(r, c));
    buildExp(first, pr, pc, r, c);
    checkOutput({tag, "_nreq"}, reqLog.size(), expQ.size());
    n = (reqLog.size() < expQ.size()) ? reqLog.size() : expQ.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s_req%0d", tag, i), reqLog[i], expQ[i]);
    reqLog.delete();
  endtask

  initial begin
    int r, c, pr, pc;

    // Reset state
    for (int i = 0; i < 16384; i++) img[i] = 8'd50;
    reset = 1'b1;
    #1;
    checkIdle("reset");
    #20;

    // Uniform image: first window, then one move right
    applyStimulus(1, 1);
    checkPixel("uni0", 10, 1'b1, 0, 0, r, c);
    checkOutput("uni0_ff", lbp_data, 8'hFF);
    checkOutput("uni0_centre", lbp_addr, addrOf(1, 1));
    checkPixel("uni1", 5, 1'b0, r, c, r, c);
    checkOutput("uni1_centre", lbp_addr, addrOf(1, 2));

    // Centre 100, all neighbours 0
    for (int i = 0; i < 16384; i++) img[i] = 8'd0;
    img[addrOf(1, 1)] = 8'd100;
    applyStimulus(1, 1);
    checkPixel("zero", 10, 1'b1, 0, 0, r, c);
    checkOutput("zero_00", lbp_data, 8'h00);

    // Neighbour k holds 99+k: only values >= 100 set their bit
    img[addrOf(0, 0)] = 8'd99;  img[addrOf(0, 1)] = 8'd100; img[addrOf(0, 2)] = 8'd101;
    img[addrOf(1, 0)] = 8'd102; img[addrOf(1, 2)] = 8'd103;
    img[addrOf(2, 0)] = 8'd104; img[addrOf(2, 1)] = 8'd105; img[addrOf(2, 2)] = 8'd106;
    applyStimulus(1, 1);
    checkPixel("ramp", 10, 1'b1, 0, 0, r, c);
    checkOutput("ramp_fe", lbp_data, 8'hFE);

    // Random image with many ties, scan across two row turns
    for (int i = 0; i < 16384; i++) img[i] = 8'($urandom_range(96, 103));
    applyStimulus(1, 1);
    checkPixel("scan0", 10, 1'b1, 0, 0, r, c);
    for (int i = 1; i < 255; i++) begin
      pr = r; pc = c;
      checkPixel($sformatf("scan%0d", i), 5, 1'b0, pr, pc, r, c);
      if (i == 126) checkOutput("turn_centre", lbp_addr, addrOf(2, 126));
    end

    // Reset in the middle of a FETCH
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkIdle("midreset");
    applyStimulus(1, 1);
    checkPixel("restart0", 10, 1'b1, 0, 0, r, c);
    for (int i = 1; i < 4; i++) begin
      pr = r; pc = c;
      checkPixel($sformatf("restart%0d", i), 5, 1'b0, pr, pc, r, c);
    end

    // End of image: last row runs left into {126,1}
    for (int i = 0; i < 16384; i++) img[i] = 8'($urandom);
    applyStimulus(126, 5);
    checkPixel("end0", 10, 1'b1, 0, 0, r, c);
    for (int i = 1; i < 5; i++) begin
      pr = r; pc = c;
      checkOutput($sformatf("end%0d_nofinish", i), finish, 0);
      checkPixel($sformatf("end%0d", i), 5, 1'b0, pr, pc, r, c);
    end
    checkOutput("last_centre", lbp_addr, addrOf(126, 1));
    @(posedge clk);
    #1;
    checkOutput("finish_rise", finish, 1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("done%0d_finish", i), finish, 1);
      checkOutput($sformatf("done%0d_req", i), gray_req, 0);
      checkOutput($sformatf("done%0d_valid", i), lbp_valid, 0);
    end
`ifdef LBP_PERF_CNT_EN
    checkOutput("fetch_cnt", fetch_cnt, 9 + 4 * 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, errCnt);
    $finish;
  end

endmodule
